// File: rtl/sram_ctrl_pkg.sv
// Shared bus definitions for the SRAM window responder: bus widths,
// access-size encodings and small helpers for decoding an access.
package sram_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 4;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);
    localparam int SRAM_SIZE   = 4096;

    // Access-size encodings shared with the interconnect and other slaves.
    typedef enum logic [ACC_W-1:0] {
        BUS_ACC_1B  = 2'd0,
        BUS_ACC_2B  = 2'd1,
        BUS_ACC_4B  = 2'd2,
        BUS_ACC_ILL = 2'd3
    } bus_acc_e;

    // An access is illegal if its size is unknown or it is not naturally aligned.
    function automatic logic acc_illegal(input logic [ACC_W-1:0] acc,
                                         input logic [1:0]       addr_lo);
        case (acc)
            BUS_ACC_1B: return 1'b0;
            BUS_ACC_2B: return addr_lo[0];
            BUS_ACC_4B: return addr_lo != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

    // Index of the last byte cycle (N-1) for a given access size.
    function automatic logic [1:0] acc_last_idx(input logic [ACC_W-1:0] acc);
        case (acc)
            BUS_ACC_2B: return 2'd1;
            BUS_ACC_4B: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Femto bus req/resp channel between the interconnect and a bus slave.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic                 s_req;
    logic [XLEN-1:0]      s_addr;
    logic                 s_w_rb;
    logic [ACC_W-1:0]     s_acc;
    logic [BUS_WIDTH-1:0] s_wdata;
    logic                 s_resp;
    logic [BUS_WIDTH-1:0] s_rdata;
    logic                 s_fault;

    modport master (
        output s_req, s_addr, s_w_rb, s_acc, s_wdata,
        input  s_resp, s_rdata, s_fault
    );

    modport slave (
        input  s_req, s_addr, s_w_rb, s_acc, s_wdata,
        output s_resp, s_rdata, s_fault
    );

endinterface

// File: rtl/sram_ctrl.sv
// SRAM window responder: splits each bus access into byte cycles on an
// external 8-bit asynchronous SRAM, each lasting WAIT_CYCLES+1 clocks.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = $clog2(SRAM_SIZE),
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 w_rb_q, w_rb_d;
    logic [1:0]           last_q, last_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [3:0]           wait_q, wait_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

    // Next values of the registered outputs.
    logic                 resp_d, fault_d;
    logic [BUS_WIDTH-1:0] s_rdata_d;
    logic [ADDR_W-1:0]    sram_addr_d;
    logic [7:0]           dq_o_d;
    logic                 dq_oe_d, ce_n_d, oe_n_d, we_n_d;

    // Upper address bits are decoded by the interconnect, not here.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.s_addr[XLEN-1:ADDR_W];

    // Next-state, datapath and pin decisions for the coming clock.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        w_rb_d      = w_rb_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        byte_idx_d  = byte_idx_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        resp_d      = 1'b0;
        fault_d     = 1'b0;
        s_rdata_d   = '0;
        sram_addr_d = sram_addr;
        dq_o_d      = sram_dq_o;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.s_req) begin
                    addr_d     = bus.s_addr[ADDR_W-1:0];
                    w_rb_d     = bus.s_w_rb;
                    last_d     = acc_last_idx(bus.s_acc);
                    wdata_d    = bus.s_wdata;
                    byte_idx_d = 2'd0;
                    wait_d     = WAIT_LOAD;
                    rdata_d    = '0;
                    if (acc_illegal(bus.s_acc, bus.s_addr[1:0])) begin
                        state_d = ST_DONE;
                        resp_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        // First byte cycle drives the pins from the accepting edge.
                        state_d     = ST_ACCESS;
                        sram_addr_d = bus.s_addr[ADDR_W-1:0];
                        dq_o_d      = bus.s_wdata[7:0];
                        ce_n_d      = 1'b0;
                        oe_n_d      = bus.s_w_rb;
                        we_n_d      = !bus.s_w_rb;
                        dq_oe_d     = bus.s_w_rb;
                    end
                end
            end

            ST_ACCESS: begin
                ce_n_d  = 1'b0;
                oe_n_d  = w_rb_q;
                dq_oe_d = w_rb_q;
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                    // Release write enable for the final clock so address/data are held past its rise.
                    we_n_d = !(w_rb_q && (wait_d != 4'd0));
                end else begin
                    if (!w_rb_q) begin
                        rdata_d[{byte_idx_q, 3'b000} +: 8] = sram_dq_i;
                    end
                    if (byte_idx_q == last_q) begin
                        state_d   = ST_DONE;
                        resp_d    = 1'b1;
                        s_rdata_d = w_rb_q ? '0 : rdata_d;
                        ce_n_d    = 1'b1;
                        oe_n_d    = 1'b1;
                        dq_oe_d   = 1'b0;
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        wait_d      = WAIT_LOAD;
                        sram_addr_d = addr_q + ADDR_W'(byte_idx_d);
                        dq_o_d      = wdata_q[{byte_idx_d, 3'b000} +: 8];
                        we_n_d      = !w_rb_q;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, with synchronous reset to the idle pin levels.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            bus.s_resp  <= 1'b0;
            bus.s_fault <= 1'b0;
            bus.s_rdata <= '0;
            sram_addr   <= '0;
            sram_dq_o   <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            bus.s_resp  <= resp_d;
            bus.s_fault <= fault_d;
            bus.s_rdata <= s_rdata_d;
            sram_addr   <= sram_addr_d;
            sram_dq_o   <= dq_o_d;
            sram_dq_oe  <= dq_oe_d;
            sram_ce_n   <= ce_n_d;
            sram_oe_n   <= oe_n_d;
            sram_we_n   <= we_n_d;
        end
    end

    // Transaction datapath: latched request, byte index, wait counter, read assembly.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every field is loaded on acceptance before anything reads it.
        addr_q     <= addr_d;
        w_rb_q     <= w_rb_d;
        last_q     <= last_d;
        wdata_q    <= wdata_d;
        byte_idx_q <= byte_idx_d;
        wait_q     <= wait_d;
        rdata_q    <= rdata_d;
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed and random bus accesses against
// a byte-array SRAM model and an independent reference of expected contents.
`timescale 1ns/1ps
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int ADDR_W   = $clog2(SRAM_SIZE);
    localparam int WAIT     = 2;
    localparam int MEM_SIZE = 1 << ADDR_W;
    localparam int BUDGET   = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dq_o, sram_dq_i;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    sram_ctrl_if bus ();

    sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_dq_o (sram_dq_o),
        .sram_dq_i (sram_dq_i),
        .sram_dq_oe(sram_dq_oe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Initial SRAM contents, with the directed test locations pinned.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h100:   return 8'h11;
            'h101:   return 8'h22;
            'h102:   return 8'h33;
            'h103:   return 8'h44;
            'h007:   return 8'hA5;
            default: return 8'((a * 37 + 11) ^ (a >> 4));
        endcase
    endfunction

    // Asynchronous SRAM model plus pin-protocol monitor, sampled on falling edges.
    logic [7:0] sram_mem [MEM_SIZE];
    int ce_low, we_low, oe_low, overlap_err, oe_dir_err, hold_err;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'h00;

    initial begin
        logic              p_we_n;
        logic [ADDR_W-1:0] p_addr;
        logic [7:0]        p_dq;
        for (int i = 0; i < MEM_SIZE; i++) sram_mem[i] = init_byte(i);
        ce_low = 0; we_low = 0; oe_low = 0;
        overlap_err = 0; oe_dir_err = 0; hold_err = 0;
        p_we_n = 1'b1; p_addr = '0; p_dq = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!sram_ce_n) ce_low++;
                if (!sram_we_n) we_low++;
                if (!sram_oe_n) oe_low++;
                if (!sram_we_n && !sram_oe_n) overlap_err++;
                if (sram_dq_oe && !sram_oe_n) oe_dir_err++;
                if (!sram_we_n && !p_we_n && (sram_addr != p_addr || sram_dq_o != p_dq)) hold_err++;
                if (sram_we_n && !p_we_n) begin
                    if (sram_addr != p_addr || sram_dq_o != p_dq || !sram_dq_oe || sram_ce_n) hold_err++;
                    sram_mem[sram_addr] = sram_dq_o;
                end
            end
            p_we_n = sram_we_n;
            p_addr = sram_addr;
            p_dq   = sram_dq_o;
        end
    end

    // Expected SRAM contents after every completed write.
    logic [7:0] ref_mem [MEM_SIZE];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One bus transaction; with keep=1 the next request follows after one idle cycle.
    task automatic do_txn(input string tag, input bit w, input int acc,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        bit          legal;
        int          n, lat, a0, idx, ce0, we0, oe0;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_f;
        legal  = !((acc == 3) || (acc == 1 && addr[0]) || (acc == 2 && addr[1:0] != 2'b00));
        n      = (acc == 0) ? 1 : (acc == 1) ? 2 : 4;
        a0     = int'(addr % MEM_SIZE);
        exp_rd = 32'h0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                idx = (a0 + i) % MEM_SIZE;
                if (w) ref_mem[idx] = wdata[8*i +: 8];
                else   exp_rd = exp_rd | (32'(ref_mem[idx]) << (8 * i));
            end
        end

        @(negedge clk);
        chk({tag, " idle pins"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        ce0 = ce_low; we0 = we_low; oe0 = oe_low;
        bus.s_req   = 1'b1;
        bus.s_w_rb  = w;
        bus.s_acc   = 2'(acc);
        bus.s_addr  = addr;
        bus.s_wdata = wdata;
        @(posedge clk);
        lat = 0;
        while (lat <= BUDGET) begin
            @(negedge clk);
            if (bus.s_resp === 1'b1) break;
            lat++;
        end
        got_rd = bus.s_rdata;
        got_f  = bus.s_fault;
        chk({tag, " latency"}, 64'(lat), legal ? 64'(n * (WAIT + 1)) : 64'd0);
        chk({tag, " rdata"}, 64'(got_rd), 64'(exp_rd));
        chk({tag, " fault"}, 64'(got_f), legal ? 64'd0 : 64'd1);
        chk({tag, " ce cycles"}, 64'(ce_low - ce0), legal ? 64'(n * (WAIT + 1)) : 64'd0);
        chk({tag, " we cycles"}, 64'(we_low - we0), (legal && w) ? 64'(n * WAIT) : 64'd0);
        chk({tag, " oe cycles"}, 64'(oe_low - oe0), (legal && !w) ? 64'(n * (WAIT + 1)) : 64'd0);
        if (legal && w) begin
            for (int i = 0; i < n; i++) begin
                idx = (a0 + i) % MEM_SIZE;
                chk({tag, " sram byte"}, 64'(sram_mem[idx]), 64'(wdata[8*i +: 8]));
            end
        end
        if (!keep) begin
            @(negedge clk);
            bus.s_req = 1'b0;
        end
    endtask

    // Directed steps followed by a random sweep.
    initial begin
        int          resp_seen;
        logic [31:0] r_addr;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1;
        bus.s_req = 1'b0; bus.s_w_rb = 1'b0; bus.s_acc = '0;
        bus.s_addr = '0;  bus.s_wdata = '0;
        repeat (3) @(negedge clk);

        chk("reset s_resp",     64'(bus.s_resp),  64'd0);
        chk("reset s_fault",    64'(bus.s_fault), 64'd0);
        chk("reset s_rdata",    64'(bus.s_rdata), 64'd0);
        chk("reset sram_addr",  64'(sram_addr),   64'd0);
        chk("reset sram_dq_o",  64'(sram_dq_o),   64'd0);
        chk("reset sram_dq_oe", 64'(sram_dq_oe),  64'd0);
        chk("reset strobes",    64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'h7);
        rst = 1'b0;

        do_txn("word read 0x100", 1'b0, 2, 32'h100, 32'h0, 1'b0);
        chk("word read 0x100 value", 64'(ref_mem['h100]), 64'h11);
        do_txn("half write 0x202", 1'b1, 1, 32'h202, 32'hBEEF, 1'b0);
        do_txn("byte read 0x7", 1'b0, 0, 32'h7, 32'h0, 1'b0);

        do_txn("illegal word 0x2", 1'b0, 2, 32'h2, 32'h0, 1'b0);
        do_txn("illegal half 0x1", 1'b1, 1, 32'h1, 32'h1234, 1'b0);
        do_txn("illegal acc3 rd", 1'b0, 3, 32'h40, 32'h0, 1'b0);
        do_txn("illegal acc3 wr", 1'b1, 3, 32'h44, 32'hFFFF_FFFF, 1'b0);

        // Reset during byte cycle 1 of a word write.
        @(negedge clk);
        bus.s_req = 1'b1; bus.s_w_rb = 1'b1; bus.s_acc = 2'd2;
        bus.s_addr = 32'h300; bus.s_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        repeat (WAIT + 1) @(posedge clk);
        @(negedge clk);
        chk("mid-reset byte1 addr", 64'(sram_addr), 64'h301);
        chk("mid-reset byte1 we_n", 64'(sram_we_n), 64'd0);
        rst = 1'b1;
        bus.s_req = 1'b0;
        @(negedge clk);
        chk("mid-reset pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        chk("mid-reset resp", 64'(bus.s_resp), 64'd0);
        rst = 1'b0;
        resp_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.s_resp) resp_seen++;
        end
        chk("mid-reset dropped", 64'(resp_seen), 64'd0);
        ref_mem['h300] = 8'h0D;
        chk("mid-reset byte0", 64'(sram_mem['h300]), 64'h0D);
        do_txn("byte read after reset", 1'b0, 0, 32'h7, 32'h0, 1'b0);

        // Top-of-window accesses issued back to back.
        do_txn("b2b half wr top", 1'b1, 1, 32'(MEM_SIZE - 2), 32'h5A3C, 1'b1);
        do_txn("b2b word rd top", 1'b0, 2, 32'(MEM_SIZE - 4), 32'h0, 1'b1);
        do_txn("b2b word wr top", 1'b1, 2, 32'(MEM_SIZE - 4), 32'h8765_4321, 1'b1);
        do_txn("b2b word misalign", 1'b0, 2, 32'(MEM_SIZE - 2), 32'h0, 1'b1);
        do_txn("b2b byte hi bits", 1'b0, 0, 32'hFFFF_0000 | 32'(MEM_SIZE - 1), 32'h0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            r_addr = $urandom();
            if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~32'h3;
            do_txn("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   r_addr, $urandom(), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        bus.s_req = 1'b0;
        repeat (2) @(negedge clk);

        chk("we/oe overlap",    64'(overlap_err), 64'd0);
        chk("dq_oe during read", 64'(oe_dir_err), 64'd0);
        chk("write hold",       64'(hold_err),    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
